// File: rtl/bmf_sweep_pkg.sv
// Shared types and helpers for the BMF partition error-evaluation sweep.
package bmf_sweep_pkg;

  // Sequencer states: idle, stepping through vectors, and one drain cycle.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Number of bits needed to hold a Hamming weight of 0..no.
  function automatic int hw_width(input int no);
    return $clog2(no + 32'sd1);
  endfunction

endpackage

// File: rtl/bmf_popcount.sv
// Combinational Hamming weight of one partition diff vector.
module bmf_popcount import bmf_sweep_pkg::*; #(
  parameter  int NO = 13,
  localparam int HW = hw_width(NO)
) (
  input  logic [NO-1:0] diff,
  output logic [HW-1:0] weight
);

  // Add up the set bits of the diff vector.
  always_comb begin
    weight = '0;
    for (int i = 0; i < NO; i++) begin
      weight = weight + HW'(diff[i]);
    end
  end

endmodule

// File: rtl/bmf_partition_sweep.sv
// Exhaustive sweep of an NI-input partition: drives every input vector to the
// approximate and exact netlists, registers their XOR difference, and
// accumulates error count, Hamming-distance sum/max and a per-bit error mask.
module bmf_partition_sweep import bmf_sweep_pkg::*; #(
  parameter  int NI = 11,
  parameter  int NO = 13,
  localparam int HW = hw_width(NO)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [NI-1:0]    vec_o,
  input  logic [NO-1:0]    appx_out,
  input  logic [NO-1:0]    exact_out,
  output logic             busy,
  output logic             done,
  output logic [NI:0]      err_cnt,
  output logic [NI+HW-1:0] hd_sum,
  output logic [HW-1:0]    hd_max,
  output logic [NO-1:0]    err_mask
);

  state_t             state_r;
  logic [NI-1:0]      vec_r;
  logic [NO-1:0]      diff_r;
  logic               valid_r;
  logic               busy_r;
  logic               done_r;
  logic [NI:0]        err_cnt_r;
  logic [NI+HW-1:0]   hd_sum_r;
  logic [HW-1:0]      hd_max_r;
  logic [NO-1:0]      err_mask_r;

  logic [HW-1:0]      weight_s;
  logic               start_ok_s;
  logic               acc_en_s;
  logic               vec_last_s;

  // A start is only honoured when idle and not cancelled in the same cycle.
  assign start_ok_s = (state_r == ST_IDLE) && start && !abort;
  // Abort suppresses the accumulate that would otherwise happen on its edge.
  assign acc_en_s   = valid_r && !abort;
  assign vec_last_s = &vec_r;

  bmf_popcount #(.NO(NO)) u_popcount (
    .diff   (diff_r),
    .weight (weight_s)
  );

  // Sequencer: stimulus counter, stage-1 diff register, busy/done flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      vec_r   <= '0;
      diff_r  <= '0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_ok_s) begin
            state_r <= ST_SWEEP;
            vec_r   <= '0;
            valid_r <= 1'b0;
            busy_r  <= 1'b1;
          end
        end
        ST_SWEEP: begin
          if (abort) begin
            state_r <= ST_IDLE;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
          end else begin
            diff_r  <= appx_out ^ exact_out;
            valid_r <= 1'b1;
            vec_r   <= vec_r + NI'(1);
            if (vec_last_s) begin
              state_r <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          state_r <= ST_IDLE;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= !abort;
        end
        default: begin
          state_r <= ST_IDLE;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Stage 2: fold the registered diff into the running statistics.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_r  <= '0;
      hd_sum_r   <= '0;
      hd_max_r   <= '0;
      err_mask_r <= '0;
    end else if (start_ok_s) begin
      err_cnt_r  <= '0;
      hd_sum_r   <= '0;
      hd_max_r   <= '0;
      err_mask_r <= '0;
    end else if (acc_en_s) begin
      err_cnt_r  <= err_cnt_r + (NI+1)'(|diff_r);
      hd_sum_r   <= hd_sum_r + (NI+HW)'(weight_s);
      hd_max_r   <= (weight_s > hd_max_r) ? weight_s : hd_max_r;
      err_mask_r <= err_mask_r | diff_r;
    end
  end

  assign vec_o    = vec_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign err_cnt  = err_cnt_r;
  assign hd_sum   = hd_sum_r;
  assign hd_max   = hd_max_r;
  assign err_mask = err_mask_r;

endmodule

// File: tb/tb_bmf_partition_sweep.sv
// Scoreboard bench for bmf_partition_sweep: a reference model sums the error
// statistics over a per-vector error pattern table; a monitor checks results
// whenever done pulses.
module tb_bmf_partition_sweep;

  typedef struct {
    int          err_cnt;
    int          hd_sum;
    int          hd_max;
    logic [12:0] err_mask;
    int          done_cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, start, abort;
  logic [10:0] vec;
  logic [12:0] appx, exact;
  logic        busy, done;
  logic [11:0] err_cnt;
  logic [14:0] hd_sum;
  logic [3:0]  hd_max;
  logic [12:0] err_mask;

  logic        s_start;
  logic [2:0]  s_vec;
  logic [3:0]  s_appx, s_exact;
  logic        s_busy, s_done;
  logic [3:0]  s_err_cnt;
  logic [5:0]  s_hd_sum;
  logic [2:0]  s_hd_max;
  logic [3:0]  s_err_mask;

  logic [12:0] pat [2048];
  exp_t        q [$];
  exp_t        me;
  int          checks = 0;
  int          failures = 0;
  int          edge_cnt = 0;

  bmf_partition_sweep #(.NI(11), .NO(13)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .vec_o(vec),
    .appx_out(appx), .exact_out(exact), .busy(busy), .done(done),
    .err_cnt(err_cnt), .hd_sum(hd_sum), .hd_max(hd_max), .err_mask(err_mask)
  );

  bmf_partition_sweep #(.NI(3), .NO(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(s_start), .abort(1'b0), .vec_o(s_vec),
    .appx_out(s_appx), .exact_out(s_exact), .busy(s_busy), .done(s_done),
    .err_cnt(s_err_cnt), .hd_sum(s_hd_sum), .hd_max(s_hd_max), .err_mask(s_err_mask)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Partitions under evaluation: exact = zero-extended input, approx = exact ^ pattern.
  always_comb begin
    exact = {2'b00, vec};
    appx  = exact ^ pat[vec];
  end

  always_comb begin
    s_exact = {1'b0, s_vec};
    s_appx  = s_exact ^ {3'b000, s_vec[0] & s_vec[1]};
  end

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Error pattern per vector: 0 identity, 1 stuck-at-0 bit 3, 2 inversion, else sparse random.
  task automatic set_pat(input int m);
    for (int v = 0; v < 2048; v++) begin
      case (m)
        0:       pat[v] = 13'h0000;
        1:       pat[v] = 13'(v) & 13'h0008;
        2:       pat[v] = 13'h1FFF;
        default: pat[v] = ($urandom_range(3) == 0) ? 13'($urandom) : 13'h0000;
      endcase
    end
  endtask

  task automatic model(output exp_t e);
    int w;
    e.err_cnt = 0; e.hd_sum = 0; e.hd_max = 0; e.err_mask = '0; e.done_cnt = 0;
    for (int v = 0; v < 2048; v++) begin
      w = $countones(pat[v]);
      if (w != 0) e.err_cnt++;
      e.hd_sum += w;
      if (w > e.hd_max) e.hd_max = w;
      e.err_mask |= pat[v];
    end
  endtask

  // Drives start for one edge; optionally queues the expected result.
  task automatic launch(input bit push, output int t0c);
    exp_t e;
    model(e);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t0c = edge_cnt;
    e.done_cnt = t0c + 2049;
    if (push) q.push_back(e);
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got done=0 expected done=1 within %0d cycles", limit);
    end
  endtask

  task automatic sweep(input int m);
    int t0c;
    set_pat(m);
    launch(1'b1, t0c);
    wait_done(2100);
  endtask

  // Scoreboard monitor: every done pulse must match the oldest queued result.
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected done=0");
      end else begin
        me = q.pop_front();
        chk("done_cycle", edge_cnt, me.done_cnt);
        chk("busy_at_done", busy, 0);
        chk("err_cnt", err_cnt, me.err_cnt);
        chk("hd_sum", hd_sum, me.hd_sum);
        chk("hd_max", hd_max, me.hd_max);
        chk("err_mask", err_mask, me.err_mask);
      end
    end
  end

  initial begin
    int t0c;
    int n;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; s_start = 1'b0;
    set_pat(0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_vec", vec, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_hd_sum", hd_sum, 0);
    chk("rst_hd_max", hd_max, 0);
    chk("rst_err_mask", err_mask, 0);

    // Directed sweeps; inversion starts in the stuck-at done cycle (back-to-back).
    sweep(0);
    @(negedge clk);
    sweep(1);
    sweep(2);
    @(negedge clk);
    sweep(3);
    @(negedge clk);
    sweep(3);

    // Abort after 100 vectors registered, with an ignored start mid-sweep.
    @(negedge clk);
    set_pat(2);
    launch(1'b0, t0c);
    repeat (49) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (50) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_err_cnt", err_cnt, 99);
    chk("abort_hd_sum", hd_sum, 1287);
    chk("abort_hd_max", hd_max, 13);
    chk("abort_err_mask", err_mask, 13'h1FFF);
    repeat (5) @(negedge clk);
    chk("abort_hold_err_cnt", err_cnt, 99);

    // Reset in the middle of a random sweep.
    @(negedge clk);
    set_pat(3);
    launch(1'b0, t0c);
    repeat (499) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("mrst_vec", vec, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_err_cnt", err_cnt, 0);
    chk("mrst_hd_sum", hd_sum, 0);
    chk("mrst_hd_max", hd_max, 0);
    chk("mrst_err_mask", err_mask, 0);
    @(negedge clk);
    sweep(3);

    // Small partition: NI=3, NO=4, error only where vec[1:0]==2'b11.
    @(negedge clk);
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    t0c = edge_cnt;
    n = 0;
    while (!s_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("small_done_cycle", edge_cnt, t0c + 9);
    chk("small_busy", s_busy, 0);
    chk("small_err_cnt", s_err_cnt, 2);
    chk("small_hd_sum", s_hd_sum, 2);
    chk("small_hd_max", s_hd_max, 1);
    chk("small_err_mask", s_err_mask, 1);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
